// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and helpers for the branch-predictor update scheduler.
// PHT index storage is sized to BP_IDX_MAX_W so the queue payload stays a fixed packed struct.
package bp_update_scheduler_pkg;

  localparam int unsigned GSHARE_GHSR_WIDTH = 8;
  localparam int unsigned GSHARE_PHT_WIDTH  = 8;
  localparam int unsigned BP_IDX_MAX_W      = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bp_state_e;

  typedef struct packed {
    logic [BP_IDX_MAX_W-1:0] idx;
    logic                    taken;
  } bp_upd_t;

  // pc[pht_w+1:2] ^ ghsr, both limited to pht_w bits
  function automatic logic [BP_IDX_MAX_W-1:0] gshare_hash(
    input logic [31:0]             pc,
    input logic [BP_IDX_MAX_W-1:0] ghsr,
    input int unsigned             pht_w
  );
    logic [BP_IDX_MAX_W-1:0] mask;
    mask = {BP_IDX_MAX_W{1'b1}} >> (BP_IDX_MAX_W - pht_w);
    return (BP_IDX_MAX_W'(pc >> 2) ^ ghsr) & mask;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-push / one-pop circular queue of PHT updates; push0 lands before push1.
module bp_upd_fifo
  import bp_update_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push0,
  input  bp_upd_t                      din0,
  input  logic                         push1,
  input  bp_upd_t                      din1,
  input  logic                         pop,
  output bp_upd_t                      head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  bp_upd_t       mem [DEPTH];

  // Payload storage needs no reset; count and pointers define validity
  always_ff @(posedge clk) begin
    if (push0) mem[wr_q] <= din0;
    if (push1) mem[push0 ? wr_q + PW'(1) : wr_q] <= din1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push0) + PW'(push1);
      rd_q  <= rd_q + PW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = mem[rd_q];

endmodule

// File: rtl/bp_update_scheduler.sv
// Serialises gshare PHT writes (init sweep and resolved-branch updates) onto the
// single PHT write port and issues GHSR restores on mispredicts.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int unsigned GHSR_W = GSHARE_GHSR_WIDTH,
  parameter int unsigned PHT_W  = GSHARE_PHT_WIDTH,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe0_valid,
  input  logic [31:0]       exe0_pc,
  input  logic              exe0_taken,
  input  logic [GHSR_W-1:0] exe0_ghsr,
  input  logic              exe0_mispredict,
  input  logic              exe1_valid,
  input  logic [31:0]       exe1_pc,
  input  logic              exe1_taken,
  input  logic [GHSR_W-1:0] exe1_ghsr,
  input  logic              exe1_mispredict,
  input  logic              pht_clear,
  output logic              exe_stall,
  output logic              pht_we,
  output logic [PHT_W-1:0]  pht_idx,
  output logic              pht_init,
  output logic              pht_taken,
  output logic              flush_valid,
  output logic [GHSR_W-1:0] restore_ghsr,
  output logic              bp_busy
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  bp_state_e        state_q, state_d;
  logic [PHT_W-1:0] sweep_q;
  logic [CW-1:0]    count, count_nxt;
  bp_upd_t          head, upd0, upd1;
  logic             accept, push0, push1, pop;

  logic              pht_we_d, pht_init_d, pht_taken_d, flush_valid_d, bp_busy_d, exe_stall_d;
  logic [PHT_W-1:0]  pht_idx_d;
  logic [GHSR_W-1:0] restore_ghsr_d;

  // Enqueue/dequeue control; lane1 is dropped behind a lane0 mispredict
  always_comb begin
    accept    = (state_q == RUN) && !exe_stall;
    push0     = accept && exe0_valid;
    push1     = accept && exe1_valid && !(exe0_valid && exe0_mispredict);
    pop       = (state_q != INIT) && (count != '0);
    count_nxt = count + CW'(push0) + CW'(push1) - CW'(pop);
    upd0.idx   = gshare_hash(exe0_pc, BP_IDX_MAX_W'(exe0_ghsr), PHT_W);
    upd0.taken = exe0_taken;
    upd1.idx   = gshare_hash(exe1_pc, BP_IDX_MAX_W'(exe1_ghsr), PHT_W);
    upd1.taken = exe1_taken;
  end

  bp_upd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .din0  (upd0),
    .push1 (push1),
    .din1  (upd1),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    pht_we_d       = 1'b0;
    pht_init_d     = 1'b0;
    pht_idx_d      = '0;
    pht_taken_d    = 1'b0;
    flush_valid_d  = 1'b0;
    restore_ghsr_d = '0;

    case (state_q)
      INIT:    if (sweep_q == '1) state_d = RUN;
      RUN:     if (pht_clear) state_d = DRAIN;
      DRAIN:   if (count == '0) state_d = INIT;
      default: state_d = INIT;
    endcase

    if (state_q == INIT) begin
      pht_we_d   = 1'b1;
      pht_init_d = 1'b1;
      pht_idx_d  = sweep_q;
    end else if (pop) begin
      pht_we_d    = 1'b1;
      pht_idx_d   = PHT_W'(head.idx);
      pht_taken_d = head.taken;
    end

    if (accept && exe0_valid && exe0_mispredict) begin
      flush_valid_d  = 1'b1;
      restore_ghsr_d = {exe0_ghsr[GHSR_W-2:0], exe0_taken};
    end else if (accept && exe1_valid && exe1_mispredict) begin
      flush_valid_d  = 1'b1;
      restore_ghsr_d = {exe1_ghsr[GHSR_W-2:0], exe1_taken};
    end

    // Stay busy until the final sweep write has actually landed
    bp_busy_d   = (state_q == INIT) || (state_d == INIT);
    exe_stall_d = (count_nxt > CW'(QDEPTH - 2)) || (state_d != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      pht_we       <= 1'b0;
      pht_init     <= 1'b0;
      pht_idx      <= '0;
      pht_taken    <= 1'b0;
      flush_valid  <= 1'b0;
      restore_ghsr <= '0;
      bp_busy      <= 1'b1;
      exe_stall    <= 1'b1;
    end else begin
      state_q      <= state_d;
      sweep_q      <= (state_q == INIT) ? sweep_q + PHT_W'(1) : '0;
      pht_we       <= pht_we_d;
      pht_init     <= pht_init_d;
      pht_idx      <= pht_idx_d;
      pht_taken    <= pht_taken_d;
      flush_valid  <= flush_valid_d;
      restore_ghsr <= restore_ghsr_d;
      bp_busy      <= bp_busy_d;
      exe_stall    <= exe_stall_d;
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler (PHT_W=8, GHSR_W=8, QDEPTH=4).
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe0_valid, exe0_taken, exe0_mispredict;
  logic [31:0] exe0_pc;
  logic [7:0]  exe0_ghsr;
  logic        exe1_valid, exe1_taken, exe1_mispredict;
  logic [31:0] exe1_pc;
  logic [7:0]  exe1_ghsr;
  logic        pht_clear;
  logic        exe_stall, pht_we, pht_init, pht_taken, flush_valid, bp_busy;
  logic [7:0]  pht_idx, restore_ghsr;

  int n_checks = 0;
  int n_pass   = 0;
  int proto_viol = 0;

  always #5 clk = ~clk;

  bp_update_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .exe0_valid      (exe0_valid),
    .exe0_pc         (exe0_pc),
    .exe0_taken      (exe0_taken),
    .exe0_ghsr       (exe0_ghsr),
    .exe0_mispredict (exe0_mispredict),
    .exe1_valid      (exe1_valid),
    .exe1_pc         (exe1_pc),
    .exe1_taken      (exe1_taken),
    .exe1_ghsr       (exe1_ghsr),
    .exe1_mispredict (exe1_mispredict),
    .pht_clear       (pht_clear),
    .exe_stall       (exe_stall),
    .pht_we          (pht_we),
    .pht_idx         (pht_idx),
    .pht_init        (pht_init),
    .pht_taken       (pht_taken),
    .flush_valid     (flush_valid),
    .restore_ghsr    (restore_ghsr),
    .bp_busy         (bp_busy)
  );

  always @(posedge clk)
    if (!reset && exe_stall && (exe0_valid || exe1_valid)) proto_viol++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] pc0, input logic [7:0] g0,
                       input logic t0, input logic m0,
                       input logic v1, input logic [31:0] pc1, input logic [7:0] g1,
                       input logic t1, input logic m1);
    exe0_valid = v0; exe0_pc = pc0; exe0_ghsr = g0; exe0_taken = t0; exe0_mispredict = m0;
    exe1_valid = v1; exe1_pc = pc1; exe1_ghsr = g1; exe1_taken = t1; exe1_mispredict = m1;
  endtask

  task automatic idle();
    drive(0, 32'h0, 8'h0, 0, 0, 0, 32'h0, 8'h0, 0, 0);
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] idx, input logic taken);
    chk({tag, "_we"}, pht_we, 1);
    chk({tag, "_init"}, pht_init, 0);
    chk({tag, "_idx"}, pht_idx, idx);
    chk({tag, "_taken"}, pht_taken, taken);
  endtask

  task automatic run_sweep(input string tag, input int first);
    int bad;
    bad = 0;
    for (int i = first; i < 256; i++) begin
      tick();
      if (pht_we !== 1'b1 || pht_init !== 1'b1 || pht_idx !== 8'(i) ||
          bp_busy !== 1'b1 || flush_valid !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    logic found;
    reset = 1'b1;
    pht_clear = 1'b0;
    idle();
    #2;
    chk("rst_busy", bp_busy, 1);
    chk("rst_stall", exe_stall, 1);
    chk("rst_we", pht_we, 0);
    chk("rst_flush", flush_valid, 0);
    chk("rst_idx", pht_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Power-on sweep: idx 0..255, then RUN
    run_sweep("sweep1_errs", 0);
    tick();
    chk("run_busy", bp_busy, 0);
    chk("run_stall", exe_stall, 0);
    chk("run_we", pht_we, 0);

    // Single lane0 update
    drive(1, 32'h0000_0040, 8'h05, 1, 0, 0, 32'h0, 8'h0, 0, 0);
    tick(); idle();
    chk("l0_lat_we", pht_we, 0);
    tick();
    chk_wr("l0", 8'h15, 1);
    tick();
    chk("l0_done_we", pht_we, 0);

    // Two lanes for two cycles
    drive(1, 32'h0000_0100, 8'h00, 0, 0, 1, 32'h0000_0104, 8'h00, 1, 0);
    tick();
    chk("dual_a_stall", exe_stall, 0);
    drive(1, 32'h0000_0200, 8'h01, 1, 0, 1, 32'h0000_03FC, 8'h0F, 0, 0);
    tick(); idle();
    chk("dual_b_stall", exe_stall, 1);
    chk_wr("dual_0a", 8'h40, 0);
    tick(); chk_wr("dual_1a", 8'h41, 1);
    tick(); chk_wr("dual_0b", 8'h81, 1);
    tick(); chk_wr("dual_1b", 8'hF0, 0);
    tick();
    chk("dual_done_we", pht_we, 0);
    chk("dual_done_stall", exe_stall, 0);

    // Both lanes mispredict: lane0 wins, lane1 squashed
    drive(1, 32'h0000_0040, 8'h81, 0, 1, 1, 32'h0000_0080, 8'h7F, 1, 1);
    tick(); idle();
    chk("mp2_flush", flush_valid, 1);
    chk("mp2_restore", restore_ghsr, 8'h02);
    tick();
    chk("mp2_flush_pulse", flush_valid, 0);
    chk_wr("mp2_l0", 8'h91, 0);
    tick();
    chk("mp2_no_l1_we", pht_we, 0);

    // Lane1-only mispredict
    drive(1, 32'h0000_0008, 8'h00, 1, 0, 1, 32'h0000_000C, 8'hF0, 1, 1);
    tick(); idle();
    chk("mp1_flush", flush_valid, 1);
    chk("mp1_restore", restore_ghsr, 8'hE1);
    tick();
    chk("mp1_flush_pulse", flush_valid, 0);
    chk_wr("mp1_l0", 8'h02, 1);
    tick(); chk_wr("mp1_l1", 8'hF3, 1);
    tick();
    chk("mp1_done_we", pht_we, 0);

    // Clear with 3 entries queued
    drive(1, 32'h0000_0010, 8'h00, 1, 0, 1, 32'h0000_0014, 8'h00, 0, 0);
    tick();
    drive(1, 32'h0000_0018, 8'h00, 1, 0, 1, 32'h0000_001C, 8'h00, 1, 0);
    tick(); idle();
    chk_wr("clr_pre", 8'h04, 1);
    pht_clear = 1'b1;
    tick();
    pht_clear = 1'b0;
    chk("clr_stall", exe_stall, 1);
    chk_wr("clr_w0", 8'h05, 0);
    tick(); chk_wr("clr_w1", 8'h06, 1);
    tick(); chk_wr("clr_w2", 8'h07, 1);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      tick();
      if (pht_we === 1'b1 && pht_init === 1'b1) found = 1'b1;
    end
    chk("sweep2_start", found, 1);
    chk("sweep2_idx0", pht_idx, 0);
    chk("sweep2_busy", bp_busy, 1);
    begin
      int bad;
      bad = 0;
      for (int i = 1; i < 100; i++) begin
        tick();
        if (pht_we !== 1'b1 || pht_init !== 1'b1 || pht_idx !== 8'(i) || bp_busy !== 1'b1) bad++;
      end
      chk("sweep2_errs", bad, 0);
    end

    // Reset mid-sweep restarts at idx 0
    reset = 1'b1;
    #1;
    chk("mid_rst_we", pht_we, 0);
    chk("mid_rst_busy", bp_busy, 1);
    chk("mid_rst_stall", exe_stall, 1);
    chk("mid_rst_idx", pht_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_sweep("sweep3_errs", 0);
    tick();
    chk("end_busy", bp_busy, 0);
    chk("end_stall", exe_stall, 0);
    chk("end_we", pht_we, 0);

    chk("protocol", proto_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sequences all writes into the gshare PHT (single write port) and produces GHSR restore/flush when a branch resolves as mispredicted.
- Accepts branch resolutions from two EXE lanes per cycle, buffers them, and drains one PHT update per cycle.
- Sweeps the PHT to weakly-taken after reset or on clear. Holds fetch prediction off (bp_busy) while sweeping.

Parameters:
- GHSR_W, 8: global history width; equals GSHARE_GHSR_WIDTH.
- PHT_W, 8: PHT index width; the PHT has 2^PHT_W entries.
- QDEPTH, 4: update queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- exe0_valid  in  1  lane0 (older) resolved conditional branch
- exe0_pc  in  32  lane0 branch PC
- exe0_taken  in  1  lane0 actual outcome
- exe0_ghsr  in  GHSR_W  GHSR checkpoint carried with lane0 branch
- exe0_mispredict  in  1  lane0 prediction was wrong
- exe1_valid, exe1_pc, exe1_taken, exe1_ghsr, exe1_mispredict  in  1/32/1/GHSR_W/1  same fields for lane1 (younger)
- pht_clear  in  1  request a full PHT re-initialise
- exe_stall  out  1  EXE must not present valid resolutions
- pht_we  out  1  PHT write strobe
- pht_idx  out  PHT_W  PHT entry to update
- pht_init  out  1  with pht_we: force entry to 2'b10; otherwise do saturating update
- pht_taken  out  1  outcome for saturating update
- flush_valid  out  1  GHSR restore strobe
- restore_ghsr  out  GHSR_W  new GHSR value
- bp_busy  out  1  predictions are invalid; fetch treats them as not-taken

Behaviour:
- Reset state is INIT with sweep index 0 and queue empty. Outputs at reset: bp_busy=1, exe_stall=1, all other outputs 0.
- States and transitions:
  - INIT → RUN after the last entry is written.
  - RUN → DRAIN when pht_clear=1.
  - DRAIN → INIT when the queue count is 0.
  - pht_clear is ignored in INIT and DRAIN.
- INIT:
  - Each cycle: pht_we=1, pht_init=1, pht_idx=sweep index; the index then increments.
  - After writing index 2^PHT_W-1, the next state is RUN. A sweep takes exactly 2^PHT_W cycles.
  - bp_busy=1 and exe_stall=1 throughout. The index wraps to 0 when leaving INIT.
- Index hash: gshare_hash(ghsr, pc) = pc[PHT_W+1:2] XOR ghsr. If GHSR_W<PHT_W, ghsr is zero-extended; if GHSR_W>PHT_W, ghsr[PHT_W-1:0] is used. The index is computed at enqueue.
- Enqueue in RUN, in order lane0 then lane1:
  - A lane enqueues when valid and not squashed.
  - Lane1 is squashed when exe0_valid and exe0_mispredict.
  - Up to two pushes per cycle.
- Dequeue:
  - In RUN or DRAIN, when the queue is non-empty, the head goes to registered pht_we/pht_idx/pht_taken next cycle with pht_init=0.
  - One pop per cycle. An entry enqueued at cycle N drives pht_we at N+1 at the earliest.
  - Simultaneous push and pop is legal; the count is updated by pushes minus pop.
- exe_stall:
  - Registered. Equals 1 when free slots after this cycle's push/pop would be fewer than 2, or when the next state is INIT or DRAIN.
  - A valid input while exe_stall=1 is a protocol error: the entry is dropped, and the bench asserts it never happens.
- Restore:
  - If exe0_valid&&exe0_mispredict: next cycle flush_valid=1, restore_ghsr={exe0_ghsr[GHSR_W-2:0],exe0_taken}. Lane0 wins if both lanes mispredict.
  - Else if exe1_valid&&exe1_mispredict: the same, using lane1 fields.
  - flush_valid is a 1-cycle pulse. It never purges the queue; the mispredicted branch itself is enqueued.
- Full/empty:
  - Pointers wrap modulo QDEPTH.
  - Count is CLOG2(QDEPTH)+1 bits wide and never exceeds QDEPTH.
  - Pop of an empty queue never occurs.
- Reset mid-operation (any state): asynchronously returns to INIT with the queue emptied and all outputs at their reset values.

Decomposition:
- Add to the common package:
  - gshare_hash function (parameterised widths)
  - bp_upd_t struct {idx, taken}
  - state enum {INIT, RUN, DRAIN}
  - defaults for GSHARE_GHSR_WIDTH and GSHARE_PHT_WIDTH
- Sub-module bp_upd_fifo: 2-push/1-pop queue of bp_upd_t exposing count. The FSM, hash, restore and stall logic stay in the top.

Test Plan (PHT_W=8, GHSR_W=8, QDEPTH=4):
- Reset release → pht_we=1, pht_init=1 for 256 consecutive cycles with idx 0..255. bp_busy=0 and exe_stall=0 by cycle 257. No flush_valid.
- RUN; lane0 only: pc=0x0000_0040, ghsr=0x05, taken=1 → next cycle pht_we=1, pht_idx=0x10^0x05=0x15, pht_taken=1, pht_init=0.
- Both lanes valid for 2 consecutive cycles, no mispredicts → exe_stall rises. Four pht_we pulses on consecutive cycles, in order lane0a, lane1a, lane0b, lane1b. Count returns to 0.
- Both mispredict: exe0_ghsr=0x81, exe0_taken=0, exe1_ghsr=0x7F → one flush_valid pulse, restore_ghsr=0x02. Only the lane0 entry is written.
- Lane1-only mispredict: ghsr=0xF0, taken=1 → restore_ghsr=0xE1. The lane0 non-mispredict entry is written before the lane1 entry.
- pht_clear with 3 queued entries → exe_stall=1, 3 normal writes, then a 256-cycle sweep with bp_busy=1. Reset asserted mid-sweep restarts the sweep at idx 0.
